// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed 32x32->64 multiplier using radix-4 Booth recoding,
// PP_PER_CYCLE digits summed per RUN cycle, valid/ready on both operand and product sides.
module booth_mult_seq #(
    parameter int PP_PER_CYCLE = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] Multiplier,
    input  logic [31:0] Multiplicand,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [63:0] Product,
    output logic        Busy
);
    localparam int SHIFT = 2 * PP_PER_CYCLE;

    generate
        if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 2 || PP_PER_CYCLE == 4 ||
              PP_PER_CYCLE == 8 || PP_PER_CYCLE == 16)) begin : g_bad_pp
            $error("booth_mult_seq: PP_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [32:0] r_mx;
    logic [63:0] r_mcand;
    logic [63:0] r_acc;
    logic [4:0]  r_idx;
    logic [63:0] w_sum;
    logic        w_last;
    logic        w_accept;

    // Multiplier and multiplicand registers are shifted each cycle, so the digits
    // for this cycle always sit at fixed positions and need no index muxing.
    function automatic logic [63:0] booth_pp(input logic [2:0] t, input logic [63:0] x);
        logic [63:0] mag;
        mag = (t == 3'b011 || t == 3'b100) ? x << 1 : (t[1] ^ t[0]) ? x : '0;
        return (t[2] && !(t[1] && t[0])) ? ~mag + 64'd1 : mag;
    endfunction

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < PP_PER_CYCLE; j++)
            w_sum = w_sum + (booth_pp(r_mx[2*j +: 3], r_mcand) << (2 * j));
    end

    assign w_last   = (r_idx + 5'(PP_PER_CYCLE)) == 5'd16;
    assign w_accept = (r_state == S_IDLE) && In_Valid;

    always_ff @(posedge Clk) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = In_Valid ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = Out_Ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_mx    <= '0;
            r_mcand <= '0;
        end else if (w_accept) begin
            r_mx    <= {Multiplier, 1'b0};
            r_mcand <= {{32{Multiplicand[31]}}, Multiplicand};
            r_acc   <= '0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= r_acc + w_sum;
            r_idx   <= r_idx + 5'(PP_PER_CYCLE);
            r_mx    <= r_mx >> SHIFT;
            r_mcand <= r_mcand << SHIFT;
        end
    end

    assign In_Ready  = (r_state == S_IDLE);
    assign Busy      = !In_Ready;
    assign Out_Valid = (r_state == S_DONE);
    assign Product   = r_acc;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: randomized and directed stimulus with a queue scoreboard;
// a monitor checks every product and its latency against a plain signed multiply.
module tb_booth_mult_seq;
    parameter int PP = 4;
    localparam int N = 16 / PP;

    logic        Clk = 0, Rst_n = 0, In_Valid = 0, Out_Ready = 1;
    logic [31:0] Multiplier = 0, Multiplicand = 0;
    logic        In_Ready, Out_Valid, Busy;
    logic [63:0] Product;

    booth_mult_seq #(.PP_PER_CYCLE(PP)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Multiplier(Multiplier), .Multiplicand(Multiplicand),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Product(Product), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int          n_vec = 0, n_err = 0, cyc = 0;
    logic [63:0] q_exp[$];
    int          q_t[$];
    bit          seen = 0;
    bit          rand_bp = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(longint'($signed(a)) * longint'($signed(b)));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on first sight of Out_Valid, product on the handshake.
    always @(negedge Clk) begin
        if (!Rst_n) seen = 0;
        else if (Out_Valid) begin
            if (!seen) begin
                seen = 1;
                if (q_t.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got product %h with nothing outstanding", Product);
                end else chk("latency", 64'(cyc - q_t.pop_front()), 64'(N));
            end
            if (Out_Ready) begin
                seen = 0;
                if (q_exp.size() != 0) chk("product", Product, q_exp.pop_front());
            end
        end
    end

    always @(posedge Clk) if (rand_bp) #1 Out_Ready = ($urandom_range(3) != 0);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        while (!In_Ready && k < 200) begin tick(); k++; end
        if (!In_Ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: In_Ready %b required 1", In_Ready);
            return;
        end
        Multiplier   = a;
        Multiplicand = b;
        In_Valid     = 1;
        q_exp.push_back(ref_mul(a, b));
        q_t.push_back(cyc + 1);
        tick();
        In_Valid     = 0;
        Multiplier   = $urandom;
        Multiplicand = $urandom;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!Out_Valid && k < 200) begin tick(); k++; end
        if (!Out_Valid) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_timeout: Out_Valid %b required 1", Out_Valid);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q_exp.size() != 0 || !In_Ready) && k < 2000) begin tick(); k++; end
        if (q_exp.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d products outstanding, required 0", q_exp.size());
        end
    endtask

    task automatic reset_checks();
        chk("rst_in_ready", 64'(In_Ready), 64'd1);
        chk("rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_product", Product, 64'd0);
    endtask

    logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    function automatic logic [31:0] pick();
        return ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
    endfunction

    initial begin
        logic [63:0] held;
        tick();
        tick();
        Rst_n = 1;
        reset_checks();

        issue(32'd3, 32'd5);
        drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(32'h7FFF_FFFF, 32'h8000_0000);
        issue(32'h8000_0000, 32'h8000_0000);
        drain();

        Out_Ready = 0;
        issue(32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid();
        held = Product;
        chk("bp_product_initial", held, ref_mul(32'h1234_5678, 32'h9ABC_DEF0));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_valid", 64'(Out_Valid), 64'd1);
            chk("bp_product_stable", Product, held);
            chk("bp_in_ready", 64'(In_Ready), 64'd0);
        end
        Out_Ready = 1;
        tick();
        chk("bp_release_in_ready", 64'(In_Ready), 64'd1);
        drain();

        issue(32'd2, 32'd9);
        Multiplier   = 32'd7;
        Multiplicand = 32'd7;
        In_Valid     = 1;
        chk("run_in_ready", 64'(In_Ready), 64'd0);
        tick();
        In_Valid = 0;
        chk("run_busy", 64'(Busy), 64'd1);
        drain();
        repeat (N + 3) tick();

        issue(32'h0BAD_F00D, 32'hDEAD_BEEF);
        tick();
        Rst_n = 0;
        tick();
        Rst_n = 1;
        q_exp.delete();
        q_t.delete();
        reset_checks();
        repeat (N + 3) tick();
        chk("rst_no_late_output", 64'(Out_Valid), 64'd0);
        issue(32'd6, 32'hFFFF_FFFC);
        drain();

        rand_bp = 1;
        for (int i = 0; i < 300; i++) begin
            issue(pick(), pick());
            repeat ($urandom_range(2)) tick();
        end
        rand_bp = 0;
        #1 Out_Ready = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
